// File: rtl/carry_lookahead_adder_4bit_if.sv
// Operand/result bundle for the registered 4-bit carry-look-ahead adder.
// The master drives the operands and observes the registered results.
// The slave (the adder) consumes the operands and drives the results.
interface carry_lookahead_adder_4bit_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] sum;
    logic       c_out;
    logic       group_p;
    logic       group_g;

    modport master (
        output a,
        output b,
        output c_in,
        input  sum,
        input  c_out,
        input  group_p,
        input  group_g
    );

    modport slave (
        input  a,
        input  b,
        input  c_in,
        output sum,
        output c_out,
        output group_p,
        output group_g
    );
endinterface

// File: rtl/carry_lookahead_adder_4bit.sv
// Registered 4-bit carry-look-ahead adder stage.
// Every carry is a flat sum-of-products over the bit generate/propagate
// terms and c_in; no carry is built from a lower carry. The result, carry
// out and group propagate/generate are registered every cycle, so the block
// behaves as a one-cycle arithmetic stage. The group outputs let several of
// these be combined by a second-level look-ahead unit.
module carry_lookahead_adder_4bit (
    input  logic                                clk,
    input  logic                                rst_n,
    carry_lookahead_adder_4bit_if.slave         bus
);

    // Bit-level generate and propagate.
    logic [3:0] gen_bit;
    logic [3:0] prop_bit;

    // carry[0] is c_in, carry[4] is the carry out of the group.
    logic [4:0] carry;

    logic [3:0] sum_d;
    logic       c_out_d;
    logic       group_p_d;
    logic       group_g_d;

    logic [3:0] sum_q;
    logic       c_out_q;
    logic       group_p_q;
    logic       group_g_q;

    genvar gi;
    genvar gj;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit_pg
            assign gen_bit[gi]  = bus.a[gi] & bus.b[gi];
            assign prop_bit[gi] = bus.a[gi] ^ bus.b[gi];
        end
    endgenerate

    assign carry[0] = bus.c_in;

    // Carry ci is the OR of one product per source: each lower generate gj
    // gated by the propagates strictly above it (p[i-1..j+1]), plus c_in
    // gated by every propagate below i. All products are formed directly
    // from the inputs, so every carry is two logic levels past p/g.
    generate
        for (gi = 1; gi <= 4; gi++) begin : g_carry
            logic [gi:0] term;
            for (gj = 0; gj < gi; gj++) begin : g_term
                if (gj == gi - 1) begin : g_top
                    assign term[gj] = gen_bit[gj];
                end else begin : g_gated
                    assign term[gj] = gen_bit[gj] & (&prop_bit[gi-1:gj+1]);
                end
            end
            assign term[gi] = carry[0] & (&prop_bit[gi-1:0]);
            assign carry[gi] = |term;
        end
    endgenerate

    // Next-state values for the output register: sum bits, carry out and
    // the c_in-independent group terms.
    always_comb begin
        sum_d     = prop_bit ^ carry[3:0];
        c_out_d   = carry[4];
        group_p_d = &prop_bit;
        group_g_d = gen_bit[3]
                  | (prop_bit[3] & gen_bit[2])
                  | (prop_bit[3] & prop_bit[2] & gen_bit[1])
                  | (prop_bit[3] & prop_bit[2] & prop_bit[1] & gen_bit[0]);
    end

    // Output register: loaded every cycle, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= 4'h0;
            c_out_q   <= 1'b0;
            group_p_q <= 1'b0;
            group_g_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            c_out_q   <= c_out_d;
            group_p_q <= group_p_d;
            group_g_q <= group_g_d;
        end
    end

    assign bus.sum     = sum_q;
    assign bus.c_out   = c_out_q;
    assign bus.group_p = group_p_q;
    assign bus.group_g = group_g_q;

endmodule

// File: tb/tb_carry_lookahead_adder_4bit.sv
// Scoreboard bench for the registered 4-bit carry-look-ahead adder.
// The driver applies operands on the falling edge and queues the expected
// result; the monitor pops one entry after every rising edge taken out of
// reset and compares it with the registered outputs.
module tb_carry_lookahead_adder_4bit;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c_in;
        logic [4:0] total;
        logic       gp;
        logic       gg;
    } exp_t;

    logic clk;
    logic rst_n;

    carry_lookahead_adder_4bit_if bus ();

    carry_lookahead_adder_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition. A group propagates exactly when
    // a+b == 15 and generates exactly when a+b overflows on its own.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic c_in);
        exp_t e;
        int   ab;
        ab      = int'(a) + int'(b);
        e.a     = a;
        e.b     = b;
        e.c_in  = c_in;
        e.total = 5'(ab + int'(c_in));
        e.gp    = (ab == 15);
        e.gg    = (ab > 15);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive one operand set on the falling edge and record its expectation.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c_in);
        @(negedge clk);
        bus.a    = a;
        bus.b    = b;
        bus.c_in = c_in;
        exp_q.push_back(model(a, b, c_in));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " sum"},     int'(bus.sum),     0);
        check({tag, " c_out"},   int'(bus.c_out),   0);
        check({tag, " group_p"}, int'(bus.group_p), 0);
        check({tag, " group_g"}, int'(bus.group_g), 0);
    endtask

    // Monitor: one result per rising edge while out of reset.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn a=%h b=%h c_in=%0d -> sum=%h c_out=%0d gp=%0d gg=%0d (exp %h/%0d/%0d/%0d)",
                     e.a, e.b, e.c_in, bus.sum, bus.c_out, bus.group_p, bus.group_g,
                     e.total[3:0], e.total[4], e.gp, e.gg);
            check("sum",     int'(bus.sum),     int'(e.total[3:0]));
            check("c_out",   int'(bus.c_out),   int'(e.total[4]));
            check("group_p", int'(bus.group_p), int'(e.gp));
            check("group_g", int'(bus.group_g), int'(e.gg));
            check("carry_identity", int'(bus.c_out),
                  int'(bus.group_g | (bus.group_p & e.c_in)));
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        bus.a    = 4'hF;
        bus.b    = 4'hF;
        bus.c_in = 1'b1;

        // Held in reset with worst-case operands while the clock runs.
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, then back-to-back pipeline sequence.
        drive(4'h3, 4'h5, 1'b0);
        drive(4'hA, 4'h5, 1'b1);
        drive(4'hA, 4'h5, 1'b0);
        drive(4'hF, 4'hF, 1'b1);
        drive(4'h3, 4'h4, 1'b0);
        drive(4'h9, 4'h9, 1'b1);
        drive(4'h0, 4'h0, 1'b0);

        // Nonzero result, then reset mid-cycle: outputs must clear at once.
        drive(4'h7, 4'h6, 1'b1);
        @(posedge clk);
        #3;
        check("pre_reset sum", int'(bus.sum), 4'hE);
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset_clocked");
        check("queue_drained_at_reset", exp_q.size(), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep of every operand combination.
        for (int i = 0; i < 512; i++) begin
            drive(4'(i >> 5), 4'(i >> 1), 1'(i));
        end

        // Random draws.
        for (int i = 0; i < 40; i++) begin
            drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
        end

        // Let the last result reach the monitor.
        repeat (2) @(posedge clk);
        #2;
        check("queue_empty_at_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
